// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger.
// Holds the FSM state enum, echo-to-cm scale and the no-object code.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE_OK,
        DONE_ERR
    } state_t;

    // Round-trip echo time per centimetre, in microseconds.
    localparam int US_PER_CM = 58;

    // Reported when nothing was measured; far above any proximity alarm.
    localparam logic [9:0] DIST_NONE = 10'd1023;

    function automatic int clks_per_us(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins and result bundle of the ultrasonic ranger.
// Ports: enable, echo in; trig, distance, distance_valid, timeout_err out.
interface ultrasonic_ranger_if;

    logic       enable;
    logic       echo;
    logic       trig;
    logic [9:0] distance;
    logic       distance_valid;
    logic       timeout_err;

    modport master (
        output enable,
        output echo,
        input  trig,
        input  distance,
        input  distance_valid,
        input  timeout_err
    );

    modport slave (
        input  enable,
        input  echo,
        output trig,
        output distance,
        output distance_valid,
        output timeout_err
    );

endinterface

// File: rtl/ultrasonic_ranger_tick_gen.sv
// Free-running 1 us tick generator.
// Ports: clk, reset (async, active-low), tick_1us (one-clk pulse).
module us_tick_gen
    import ultrasonic_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_1us
);

    localparam int DIV = clks_per_us(CLK_FREQ_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_1us = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width to whole cm.
// Ports: clk, reset (async, active-low), bus (ultrasonic_ranger_if.slave).
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TRIG_US     = 10,
    parameter int PERIOD_MS   = 60,
    parameter int TIMEOUT_MS  = 30,
    parameter int MAX_CM      = 400
) (
    input logic                clk,
    input logic                reset,
    ultrasonic_ranger_if.slave bus
);

    localparam int DIV        = clks_per_us(CLK_FREQ_HZ);
    localparam int TRIG_CLKS  = TRIG_US * DIV;
    localparam int TW         = $clog2(TRIG_CLKS + 1);
    localparam int PERIOD_US  = PERIOD_MS * 1000;
    localparam int PW         = $clog2(PERIOD_US + 1);
    localparam int TIMEOUT_US = TIMEOUT_MS * 1000;
    localparam int UW         = $clog2(TIMEOUT_US + 1);

    localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CLKS - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_US - 1);
    localparam logic [UW-1:0] TIMEOUT_LIM = UW'(TIMEOUT_US);
    localparam logic [9:0]    MAX_LIM     = 10'(MAX_CM);
    localparam logic [5:0]    SUB_LAST    = 6'(US_PER_CM - 1);

    state_t        state;
    state_t        next_state;
    logic          tick_1us;
    logic          echo_m;
    logic          echo_s;
    logic          echo_d;
    logic          rise;
    logic          fall;
    logic          count_en;
    logic [TW-1:0] trig_cnt;
    logic [PW-1:0] per_cnt;
    logic          period_done;
    logic [UW-1:0] us_cnt;
    logic [5:0]    sub_cnt;
    logic [9:0]    cm;
    logic          trig_q;
    logic [9:0]    dist_q;
    logic          valid_q;
    logic          err_q;

    us_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .tick_1us(tick_1us)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= bus.echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (period_done) next_state = TRIG;
            end
            TRIG: begin
                if (trig_cnt == TRIG_LAST) next_state = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    next_state = MEASURE;
                end else if (us_cnt >= TIMEOUT_LIM) begin
                    next_state = DONE_ERR;
                end
            end
            MEASURE: begin
                // Out of range wins so an over-range count is never reported.
                if (cm > MAX_LIM) begin
                    next_state = DONE_ERR;
                end else if (fall) begin
                    next_state = DONE_OK;
                end else if (us_cnt >= TIMEOUT_LIM) begin
                    next_state = DONE_ERR;
                end
            end
            DONE_OK:  next_state = IDLE;
            DONE_ERR: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (!bus.enable) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_cnt <= '0;
        end else if (state == TRIG) begin
            trig_cnt <= trig_cnt + 1'b1;
        end else begin
            trig_cnt <= '0;
        end
    end

    // period_done starts set so the first trigger after enable is immediate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt     <= '0;
            period_done <= 1'b1;
        end else if (!bus.enable) begin
            per_cnt     <= '0;
            period_done <= 1'b1;
        end else if (state != TRIG && next_state == TRIG) begin
            per_cnt     <= '0;
            period_done <= 1'b0;
        end else if (tick_1us && !period_done) begin
            per_cnt <= per_cnt + 1'b1;
            if (per_cnt == PERIOD_LAST) period_done <= 1'b1;
        end
    end

    // Shared timeout timer: echo wait, then echo high time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            us_cnt <= '0;
        end else if (state == WAIT_RISE && rise) begin
            us_cnt <= '0;
        end else if (state == WAIT_RISE || state == MEASURE) begin
            if (tick_1us && us_cnt != TIMEOUT_LIM) begin
                us_cnt <= us_cnt + 1'b1;
            end
        end else begin
            us_cnt <= '0;
        end
    end

    // The rise cycle itself counts, so N us of echo yields exactly N ticks.
    assign count_en = tick_1us & echo_s &
                      ((state == MEASURE) |
                       ((state == WAIT_RISE) & rise));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt <= '0;
            cm      <= '0;
        end else if (state == TRIG ||
                     (state == WAIT_RISE && !rise)) begin
            sub_cnt <= '0;
            cm      <= '0;
        end else if (count_en) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                if (cm != DIST_NONE) cm <= cm + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    // Outputs follow next_state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q  <= 1'b0;
            dist_q  <= DIST_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            trig_q  <= (next_state == TRIG);
            valid_q <= (next_state == DONE_OK) ||
                       (next_state == DONE_ERR);
            err_q   <= (next_state == DONE_ERR);
            if (next_state == DONE_OK) begin
                dist_q <= cm;
            end else if (next_state == DONE_ERR) begin
                dist_q <= DIST_NONE;
            end
        end
    end

    assign bus.trig           = trig_q;
    assign bus.distance       = dist_q;
    assign bus.distance_valid = valid_q;
    assign bus.timeout_err    = err_q;

endmodule
